timer_mc: RTL and testbench

- Parametrised multi-channel down-counting timer on the picorv32 native memory bus. It is the successor to the single timer peripheral.
- Provides CHANNELS independent counters behind one shared prescaler.
- Each channel runs in one-shot or periodic auto-reload mode.
- Each channel has a sticky expiry flag and a maskable interrupt line. The interrupt lines feed the CPU irq vector.
- Sits beside gpio/uart peripherals. It is selected by an address-decoder enable, and its rdata/ready are OR-combined with the other peripherals.

---
 rtl/timer_mc.sv | 259 +++++++++++++++++++++++++
 tb/tb_timer_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mc.sv
// timer_mc: multi-channel down-counting timer on the picorv32 native bus.
// CHANNELS independent counters share one prescaler. Each counter runs in
// one-shot or periodic auto-reload mode, sets a sticky STATUS bit on expiry
// and drives a level interrupt gated by IRQEN.
//
// Word map (mem_addr[7:2]):
//   0 PRESCALE, 1 STATUS (W1C), 2 IRQEN, 3 reserved,
//   4+4c CTRL_c {PERIODIC, EN}, 5+4c LOAD_c, 6+4c COUNT_c, 7+4c reserved.
// Anything unmapped reads 0 and ignores writes.

module timer_mc #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [3:0]          mem_wstrb,
    input  logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_addr,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    localparam logic [5:0] W_PRESCALE = 6'd0;
    localparam logic [5:0] W_STATUS   = 6'd1;
    localparam logic [5:0] W_IRQEN    = 6'd2;

    logic        ready_reg;
    logic [31:0] rdata_reg;
    logic [31:0] read_val;
    logic        bus_req;
    logic        bus_wr;
    logic        bus_rd;
    logic [5:0]  word;
    logic [3:0]  ch_idx;
    logic [31:0] wmask;

    // A new access is only taken while not acknowledging the previous one,
    // so mem_ready is a single-cycle pulse per request.
    assign bus_req = mem_valid & enable & ~ready_reg;
    assign bus_wr  = bus_req & (|mem_wstrb);
    assign bus_rd  = bus_req & ~(|mem_wstrb);
    assign word    = mem_addr[7:2];

    // Channel slot for words 4..63; words 0..3 map to 15 and never match.
    assign ch_idx  = word[5:2] - 4'd1;

    // Byte-lane mask used to merge partial writes into stored registers.
    assign wmask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                      {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

    // Address bits outside [7:2], the instruction flag and the unused top
    // bits of wide bus vectors are intentionally ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, mem_instr, mem_addr[31:8], mem_addr[1:0],
                         wmask, mem_wdata};

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [PRESCALE_W-1:0] pcnt_reg;
    logic                  tick;
    logic                  wr_prescale;

    assign wr_prescale = bus_wr && (word == W_PRESCALE);
    assign tick        = (pcnt_reg == prescale_reg);

    // PRESCALE register with per-byte write merge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescale_reg <= '0;
        end else if (wr_prescale) begin
            prescale_reg <= (prescale_reg & ~wmask[PRESCALE_W-1:0]) |
                            (mem_wdata[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
        end
    end

    // Prescale counter runs 0..PRESCALE; a PRESCALE write restarts the phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_reg <= '0;
        end else if (wr_prescale || tick) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + PRESCALE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // STATUS / IRQEN
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] status_reg;
    logic [CHANNELS-1:0] irqen_reg;
    logic [CHANNELS-1:0] status_clr;
    logic [CHANNELS-1:0] expire;
    logic [CHANNELS-1:0] en_vec;
    logic [CHANNELS-1:0] per_vec;
    logic [WIDTH-1:0]    load_vec  [CHANNELS];
    logic [WIDTH-1:0]    count_vec [CHANNELS];

    // At most 8 channels, so the W1C bits all live in byte lane 0.
    assign status_clr = (bus_wr && (word == W_STATUS) && mem_wstrb[0]) ?
                        mem_wdata[CHANNELS-1:0] : '0;

    // Sticky expiry flags: hardware set is applied after the W1C clear so a
    // coincident expiry is never lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_reg <= '0;
        end else begin
            status_reg <= (status_reg & ~status_clr) | expire;
        end
    end

    // Interrupt enable mask.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irqen_reg <= '0;
        end else if (bus_wr && (word == W_IRQEN)) begin
            irqen_reg <= (irqen_reg & ~wmask[CHANNELS-1:0]) |
                         (mem_wdata[CHANNELS-1:0] & wmask[CHANNELS-1:0]);
        end
    end

    assign irq     = status_reg & irqen_reg;
    assign irq_any = |irq;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam logic [5:0] W_CTRL  = 6'(4 + 4 * gi);
        localparam logic [5:0] W_LOAD  = 6'(5 + 4 * gi);
        localparam logic [5:0] W_COUNT = 6'(6 + 4 * gi);

        logic             en_reg;
        logic             periodic_reg;
        logic [WIDTH-1:0] load_reg;
        logic [WIDTH-1:0] count_reg;
        logic             wr_ctrl;
        logic             wr_load;
        logic             wr_count;
        logic             en_new;
        logic             per_new;
        logic             at_zero;
        logic             tick_ch;

        assign wr_ctrl  = bus_wr && (word == W_CTRL);
        assign wr_load  = bus_wr && (word == W_LOAD);
        assign wr_count = bus_wr && (word == W_COUNT);
        assign en_new   = mem_wstrb[0] ? mem_wdata[0] : en_reg;
        assign per_new  = mem_wstrb[0] ? mem_wdata[1] : periodic_reg;
        assign at_zero  = (count_reg == '0);

        // A bus write to CTRL or COUNT owns this channel for the cycle, so
        // the tick is not applied to it.
        assign tick_ch     = tick && en_reg && !wr_ctrl && !wr_count;
        assign expire[gi]  = tick_ch && at_zero;

        // CTRL: software write, or one-shot self-disable on expiry.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                en_reg       <= 1'b0;
                periodic_reg <= 1'b0;
            end else if (wr_ctrl) begin
                en_reg       <= en_new;
                periodic_reg <= per_new;
            end else if (expire[gi] && !periodic_reg) begin
                en_reg       <= 1'b0;
            end
        end

        // LOAD only feeds the next reload; a running count is untouched.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                load_reg <= '0;
            end else if (wr_load) begin
                load_reg <= (load_reg & ~wmask[WIDTH-1:0]) |
                            (mem_wdata[WIDTH-1:0] & wmask[WIDTH-1:0]);
            end
        end

        // COUNT: bus write, start-load on EN rising, else count down and
        // reload (periodic) or park at 0 (one-shot) on expiry.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                count_reg <= '0;
            end else if (wr_count) begin
                count_reg <= (count_reg & ~wmask[WIDTH-1:0]) |
                             (mem_wdata[WIDTH-1:0] & wmask[WIDTH-1:0]);
            end else if (wr_ctrl && !en_reg && en_new) begin
                count_reg <= load_reg;
            end else if (tick_ch) begin
                if (!at_zero) begin
                    count_reg <= count_reg - WIDTH'(1);
                end else if (periodic_reg) begin
                    count_reg <= load_reg;
                end
            end
        end

        assign en_vec[gi]    = en_reg;
        assign per_vec[gi]   = periodic_reg;
        assign load_vec[gi]  = load_reg;
        assign count_vec[gi] = count_reg;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Read multiplexer; unmapped, reserved and absent channels give 0.
    always_comb begin
        read_val = '0;
        case (word)
            W_PRESCALE: read_val = 32'(prescale_reg);
            W_STATUS:   read_val = 32'(status_reg);
            W_IRQEN:    read_val = 32'(irqen_reg);
            default: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ch_idx == 4'(c)) begin
                        case (word[1:0])
                            2'd0:    read_val = 32'({per_vec[c], en_vec[c]});
                            2'd1:    read_val = 32'(load_vec[c]);
                            2'd2:    read_val = 32'(count_vec[c]);
                            default: read_val = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Handshake: acknowledge one cycle after the request; rdata is only
    // non-zero in the acknowledge cycle of a read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ready_reg <= bus_req;
            rdata_reg <= bus_rd ? read_val : '0;
        end
    end

    assign mem_ready = ready_reg;
    assign mem_rdata = rdata_reg;

endmodule

// File: tb/tb_timer_mc.sv
// Directed bench for timer_mc. Instance A uses default parameters,
// instance B a narrow configuration (2 channels, 16-bit counters,
// 8-bit prescaler). Read expectations go through a scoreboard queue.
`timescale 1ns/1ps

module tb_timer_mc;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_addr = 32'h0;

    logic        ready_a, ready_b;
    logic [31:0] rdata_a, rdata_b;
    logic [3:0]  irq_a;
    logic [1:0]  irq_b;
    logic        irq_any_a, irq_any_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [31:0] exp_q[$];
    int rise0_q[$];
    int rise1_q[$];
    logic p0 = 1'b0;
    logic p1 = 1'b0;

    timer_mc dut_a (
        .clk(clk), .resetn(resetn), .enable(en_a), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_ready(ready_a), .mem_rdata(rdata_a),
        .irq(irq_a), .irq_any(irq_any_a)
    );

    timer_mc #(.CHANNELS(2), .WIDTH(16), .PRESCALE_W(8)) dut_b (
        .clk(clk), .resetn(resetn), .enable(en_b), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_ready(ready_b), .mem_rdata(rdata_b),
        .irq(irq_b), .irq_any(irq_any_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle number of every rising edge of irq[0] / irq[1].
    always @(negedge clk) begin
        if (irq_a[0] && !p0) rise0_q.push_back(cyc);
        if (irq_a[1] && !p1) rise1_q.push_back(cyc);
        p0 = irq_a[0];
        p1 = irq_a[1];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One bus transaction; read expectations are queued at drive time and
    // popped when the acknowledge appears.
    task automatic bus(input bit b, input int word, input logic [3:0] st,
                       input logic [31:0] wd, input bit chk,
                       input logic [31:0] expv, input string tag);
        int guard = 0;
        logic [31:0] e;
        logic rdy;
        logic [31:0] rd;
        @(negedge clk);
        while ((ready_a || ready_b) && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        mem_valid = 1'b1;
        en_a = !b;
        en_b = b;
        mem_addr = 32'(word) << 2;
        mem_wstrb = st;
        mem_wdata = wd;
        if (chk) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        rdy = b ? ready_b : ready_a;
        rd = b ? rdata_b : rdata_a;
        mem_valid = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        mem_wstrb = 4'h0;
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        if (chk) begin
            e = exp_q.pop_front();
            check(tag, rd, e);
        end
        $display("bus %s dut=%0d word=%0d wstrb=%b wdata=%h rdata=%h", tag, b, word, st, wd, rd);
    endtask

    task automatic wait_rise(input int ch, input int maxc, input string tag, output int t);
        int n = 0;
        t = -1;
        while (n < maxc) begin
            if (ch == 0 && rise0_q.size() > 0) begin t = rise0_q.pop_front(); break; end
            if (ch == 1 && rise1_q.size() > 0) begin t = rise1_q.pop_front(); break; end
            @(negedge clk);
            n++;
        end
        if (t < 0) begin
            total++;
            bad++;
            $error("FAIL %s: no expiry within %0d cycles", tag, maxc);
        end
    endtask

    initial begin
        int t;
        int tw;
        int prev;

        // ---------------- 1: reset state and empty register file ----------
        repeat (3) @(negedge clk);
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_irq_a", 32'(irq_a), 32'd0);
        check("rst_irq_any_a", 32'(irq_any_a), 32'd0);
        resetn = 1'b1;
        for (int w = 0; w < 20; w++) bus(0, w, 4'h0, 32'h0, 1, 32'h0, "t1_rd_a");
        for (int w = 0; w < 12; w++) bus(1, w, 4'h0, 32'h0, 1, 32'h0, "t1_rd_b");
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("t1_noen_ready", 32'(ready_a), 32'd0);
            check("t1_noen_rdata", rdata_a, 32'd0);
        end
        mem_valid = 1'b0;

        // ---------------- 2: periodic channel 0, prescale 3 ---------------
        bus(0, 0, 4'hF, 32'd3, 0, 0, "t2_prescale");
        bus(0, 5, 4'hF, 32'd2, 0, 0, "t2_load0");
        bus(0, 2, 4'hF, 32'd1, 0, 0, "t2_irqen");
        rise0_q.delete();
        bus(0, 4, 4'hF, 32'd3, 0, 0, "t2_ctrl0");
        tw = acc_cyc;
        wait_rise(0, 40, "t2_first", t);
        check("t2_first_delay", 32'(t - tw), 32'd10);
        check("t2_irq", 32'(irq_a), 32'h1);
        check("t2_irq_any", 32'(irq_any_a), 32'd1);
        for (int k = 0; k < 2; k++) begin
            bus(0, 1, 4'hF, 32'h1, 0, 0, "t2_w1c");
            check("t2_irq_cleared", 32'(irq_a), 32'h0);
            check("t2_irq_any_cleared", 32'(irq_any_a), 32'd0);
            prev = t;
            wait_rise(0, 40, "t2_next", t);
            check("t2_period", 32'(t - prev), 32'd12);
        end

        // ---------------- 3: one-shot channel 1 ----------------------------
        bus(0, 4, 4'hF, 32'd0, 0, 0, "t3_ctrl0_off");
        bus(0, 1, 4'hF, 32'hFF, 0, 0, "t3_w1c_all");
        bus(0, 2, 4'hF, 32'd2, 0, 0, "t3_irqen");
        bus(0, 0, 4'hF, 32'd0, 0, 0, "t3_prescale");
        bus(0, 9, 4'hF, 32'd5, 0, 0, "t3_load1");
        rise1_q.delete();
        bus(0, 8, 4'hF, 32'd1, 0, 0, "t3_ctrl1");
        tw = acc_cyc;
        wait_rise(1, 30, "t3_expiry", t);
        check("t3_delay", 32'(t - tw), 32'd6);
        check("t3_irq", 32'(irq_a), 32'h2);
        check("t3_irq_any", 32'(irq_any_a), 32'd1);
        bus(0, 8, 4'h0, 32'h0, 1, 32'h0, "t3_ctrl1_rd");
        bus(0, 10, 4'h0, 32'h0, 1, 32'h0, "t3_count1_rd");
        bus(0, 1, 4'h0, 32'h0, 1, 32'h2, "t3_status_rd");
        bus(0, 1, 4'hF, 32'h2, 0, 0, "t3_w1c");
        repeat (20) @(negedge clk);
        bus(0, 1, 4'h0, 32'h0, 1, 32'h0, "t3_status_idle");
        check("t3_no_reexpire", 32'(rise1_q.size()), 32'd0);

        // ---------------- 4: byte lanes and width limits -------------------
        bus(0, 13, 4'hF, 32'h11223344, 0, 0, "t4_load2_full");
        bus(0, 13, 4'b0010, 32'hAABBCCDD, 0, 0, "t4_load2_lane1");
        bus(0, 13, 4'h0, 32'h0, 1, 32'h1122CC44, "t4_load2_rd1");
        bus(0, 13, 4'b1000, 32'hAABBCCDD, 0, 0, "t4_load2_lane3");
        bus(0, 13, 4'h0, 32'h0, 1, 32'hAA22CC44, "t4_load2_rd2");
        bus(0, 7, 4'hF, 32'hFFFFFFFF, 0, 0, "t4_resv7_wr");
        bus(0, 7, 4'h0, 32'h0, 1, 32'h0, "t4_resv7_rd");
        bus(0, 3, 4'hF, 32'hFFFFFFFF, 0, 0, "t4_resv3_wr");
        bus(0, 3, 4'h0, 32'h0, 1, 32'h0, "t4_resv3_rd");
        bus(0, 21, 4'hF, 32'hFFFFFFFF, 0, 0, "t4_ch4_wr");
        bus(0, 21, 4'h0, 32'h0, 1, 32'h0, "t4_ch4_rd");
        bus(1, 5, 4'hF, 32'hFFFFFFFF, 0, 0, "t4_b_load0_wr");
        bus(1, 5, 4'h0, 32'h0, 1, 32'h0000FFFF, "t4_b_load0_rd");
        bus(1, 0, 4'hF, 32'hFFFFFFFF, 0, 0, "t4_b_prescale_wr");
        bus(1, 0, 4'h0, 32'h0, 1, 32'h000000FF, "t4_b_prescale_rd");
        bus(1, 2, 4'hF, 32'hFFFFFFFF, 0, 0, "t4_b_irqen_wr");
        bus(1, 2, 4'h0, 32'h0, 1, 32'h3, "t4_b_irqen_rd");
        bus(1, 12, 4'hF, 32'h3, 0, 0, "t4_b_ctrl2_wr");
        bus(1, 12, 4'h0, 32'h0, 1, 32'h0, "t4_b_ctrl2_rd");

        // ---------------- 5: simultaneous events ---------------------------
        bus(0, 1, 4'hF, 32'hFF, 0, 0, "t5_w1c_all");
        bus(0, 5, 4'hF, 32'd1, 0, 0, "t5_load0");
        bus(0, 4, 4'hF, 32'd3, 0, 0, "t5_ctrl0");
        bus(0, 1, 4'hF, 32'h1, 0, 0, "t5_w1c_on_expiry");
        bus(0, 1, 4'h0, 32'h0, 1, 32'h1, "t5_status_kept");
        bus(0, 4, 4'hF, 32'd0, 0, 0, "t5_ctrl0_off");
        bus(0, 1, 4'hF, 32'hFF, 0, 0, "t5_w1c_all2");
        bus(0, 0, 4'hF, 32'd3, 0, 0, "t5_prescale");
        bus(0, 5, 4'hF, 32'd100, 0, 0, "t5_load0_100");
        bus(0, 4, 4'hF, 32'd1, 0, 0, "t5_ctrl0_on");
        bus(0, 2, 4'hF, 32'd0, 0, 0, "t5_irqen_off");
        bus(0, 6, 4'hF, 32'd7, 0, 0, "t5_count0_on_tick");
        bus(0, 6, 4'h0, 32'h0, 1, 32'd7, "t5_count0_rd1");
        bus(0, 6, 4'h0, 32'h0, 1, 32'd7, "t5_count0_rd2");
        bus(0, 6, 4'h0, 32'h0, 1, 32'd6, "t5_count0_rd3");

        // ---------------- 6: reset during active counting -----------------
        bus(0, 4, 4'hF, 32'd0, 0, 0, "t6_ctrl0_off");
        bus(0, 0, 4'hF, 32'd0, 0, 0, "t6_prescale");
        bus(0, 5, 4'hF, 32'd3, 0, 0, "t6_load0");
        bus(0, 2, 4'hF, 32'd1, 0, 0, "t6_irqen");
        bus(0, 1, 4'hF, 32'hFF, 0, 0, "t6_w1c_all");
        rise0_q.delete();
        bus(0, 4, 4'hF, 32'd3, 0, 0, "t6_ctrl0");
        wait_rise(0, 20, "t6_expiry", t);
        @(negedge clk);
        mem_valid = 1'b1;
        en_a = 1'b1;
        mem_addr = 32'h0;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("t6_ready_pre", 32'(ready_a), 32'd1);
        check("t6_irq_any_pre", 32'(irq_any_a), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_ready_rst", 32'(ready_a), 32'd0);
        check("t6_rdata_rst", rdata_a, 32'd0);
        check("t6_irq_rst", 32'(irq_a), 32'd0);
        check("t6_irq_any_rst", 32'(irq_any_a), 32'd0);
        mem_valid = 1'b0;
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_irq_idle", 32'(irq_a), 32'd0);
        bus(0, 6, 4'h0, 32'h0, 1, 32'd0, "t6_count0_rd");
        bus(0, 4, 4'h0, 32'h0, 1, 32'd0, "t6_ctrl0_rd");
        bus(0, 5, 4'h0, 32'h0, 1, 32'd0, "t6_load0_rd");
        bus(0, 1, 4'h0, 32'h0, 1, 32'd0, "t6_status_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
